procc_sched: RTL

//  Sequences operand pairs out of the dual-operand RAM into the processing unit after mem_ctrl has loaded a block.
//  On start, walks addresses 0..length-1, reads opa/opb at the same address and holds each pair.

---
 rtl/procc_sched_if.sv | 36 +++
 rtl/procc_sched.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/procc_sched_if.sv
// rtl/procc_sched_if.sv - operand RAM read port and processing-unit handshake bundle
//
// Signals:
//   sch_address_mem_opa/opb  scheduler -> RAM   read addresses (always equal)
//   mem_data_in_opa/opb      RAM -> scheduler   read data, RD_LAT cycles after address
//   procc_valid              scheduler -> unit  operand pair valid
//   procc_ready              unit -> scheduler  unit accepts the pair
//   procc_opa/opb            scheduler -> unit  held operands
//   procc_last               scheduler -> unit  marks the final pair of the run
// Modports: master = scheduler side, slave = RAM/processing-unit side.
interface procc_sched_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] sch_address_mem_opa;
  logic [ADDR_W-1:0] sch_address_mem_opb;
  logic [DATA_W-1:0] mem_data_in_opa;
  logic [DATA_W-1:0] mem_data_in_opb;
  logic              procc_valid;
  logic              procc_ready;
  logic [DATA_W-1:0] procc_opa;
  logic [DATA_W-1:0] procc_opb;
  logic              procc_last;

  modport master (
    output sch_address_mem_opa, sch_address_mem_opb,
    output procc_valid, procc_opa, procc_opb, procc_last,
    input  mem_data_in_opa, mem_data_in_opb, procc_ready
  );

  modport slave (
    input  sch_address_mem_opa, sch_address_mem_opb,
    input  procc_valid, procc_opa, procc_opb, procc_last,
    output mem_data_in_opa, mem_data_in_opb, procc_ready
  );
endinterface

// File: rtl/procc_sched.sv
// rtl/procc_sched.sv - walks operand RAM addresses and issues opa/opb pairs to the processing unit
//
// Ports:
//   sch_clk      in   rising-edge clock
//   sch_reset    in   synchronous active-high reset
//   sch_start    in   start pulse, honoured only when idle
//   sch_abort    in   cancels the current run (ignored when idle)
//   sch_length   in   number of operand pairs, latched on an accepted start
//   sch_busy     out  high while a run is in progress (including the done cycle)
//   sch_done     out  one-cycle pulse when a run completes
//   bus          master side of procc_sched_if: RAM read addresses/data and
//                the valid/ready operand handshake to the processing unit
module procc_sched #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              sch_clk,
  input  logic              sch_reset,
  input  logic              sch_start,
  input  logic              sch_abort,
  input  logic [ADDR_W-1:0] sch_length,
  output logic              sch_busy,
  output logic              sch_done,
  procc_sched_if.master     bus
);

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;

  logic is_last;
  logic handshake;

  // len_q is never 0 while a pair is outstanding, so length-1 cannot underflow
  // when it matters; outside ISSUE the result is masked by procc_valid.
  assign is_last   = (idx_q == (len_q - ADDR_W'(1)));
  assign handshake = (state_q == S_ISSUE) && bus.procc_ready;

  always_ff @(posedge sch_clk) begin
    if (sch_reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;

    case (state_q)
      S_IDLE: begin
        if (sch_start) begin
          if (sch_length != '0) begin
            len_d   = sch_length;
            idx_d   = '0;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        cnt_d   = CNT_W'(RD_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // The address was sampled at the end of FETCH, so the RAM output is
        // valid in the last WAIT cycle. An abort leaves the operands untouched.
        if (cnt_q == CNT_W'(1)) begin
          if (!sch_abort) begin
            opa_d = bus.mem_data_in_opa;
            opb_d = bus.mem_data_in_opb;
          end
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ISSUE: begin
        if (handshake) begin
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every transition out of a busy state; a handshake in
    // the same cycle still counts as taken by the unit.
    if ((state_q != S_IDLE) && sch_abort) begin
      state_d = S_IDLE;
    end
  end

  assign sch_busy = (state_q != S_IDLE);
  assign sch_done = (state_q == S_DONE) && !sch_abort;

  // idx_q only moves on entry to FETCH, so it doubles as the held address
  // that persists through DONE/IDLE.
  assign bus.sch_address_mem_opa = idx_q;
  assign bus.sch_address_mem_opb = idx_q;
  assign bus.procc_valid         = (state_q == S_ISSUE);
  assign bus.procc_opa           = opa_q;
  assign bus.procc_opb           = opb_q;
  assign bus.procc_last          = (state_q == S_ISSUE) && is_last;

endmodule
